// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with watermarks, sticky errors and read-valid strobe
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   count
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C = (ADDR_WIDTH + 1)'(AE_THRESH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign full = count == DEPTH_C;
  assign empty = count == '0;
  assign almost_full = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  always_ff @(posedge clk) if (wr_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(wr_ok);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(rd_ok);
      count <= count + (ADDR_WIDTH + 1)'(wr_ok) - (ADDR_WIDTH + 1)'(rd_ok);
      overflow <= (overflow && !err_clr) || (wr_en && full);
      underflow <= (underflow && !err_clr) || (rd_en && empty);
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem[rd_ptr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk)
    if (!reset_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) data_out <= mem[rd_ptr];
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for sync_fifo_param (DEPTH=8, AF=6, AE=1)
module tb_sync_fifo_param;
  localparam int D = 8;
  logic clk = 1'b0, reset_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  logic [7:0] mq[$], exp_q[$];
  int n_checks = 0, n_err = 0;
  always #5 clk = ~clk;
  sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr), .count(count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference queue decides acceptance from the pre-edge occupancy and queues expected read data
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w;
    data_in = d;
    rd_en = r;
    if (!reset_n) mq.delete();
    else begin
      bit ra, wa;
      ra = r && mq.size() > 0;
      wa = w && mq.size() < D;
      if (ra) exp_q.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask
`ifndef SYNC_FIFO_FWFT_EN
  always @(negedge clk)
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 data %0h expected no read", data_out);
      end else chk("rd_data", data_out, exp_q.pop_front());
    end
`endif
  initial begin
    reset_n = 1'b0;
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    reset_n = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    step(1, 8'h55, 0);
    chk("fwft_data", data_out, 8'h55);
    chk("fwft_valid", rd_valid, 1);
    step(0, 8'h00, 1);
    chk("fwft_empty", empty, 1);
    chk("fwft_valid_off", rd_valid, 0);
    chk("fwft_data_zero", data_out, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1, 8'(8'h10 + i), 0);
      chk("fill_count", count, i + 1);
      chk("fill_ae", almost_empty, (i + 1) <= 1);
      chk("fill_af", almost_full, (i + 1) >= 6);
      chk("fill_full", full, (i + 1) == 8);
    end
    step(1, 8'hAA, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
`ifndef SYNC_FIFO_FWFT_EN
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1);
      chk("drain_count", count, 7 - i);
    end
    step(0, 8'h00, 1);
    chk("unf_flag", underflow, 1);
    chk("unf_hold", data_out, 8'h17);
    chk("unf_valid", rd_valid, 0);
    chk("ovf_sticky", overflow, 1);
    err_clr = 1'b1;
    step(0, 8'h00, 1);
    err_clr = 1'b0;
    chk("clr_vs_err_unf", underflow, 1);
    chk("clr_ovf", overflow, 0);
    err_clr = 1'b1;
    step(0, 8'h00, 0);
    err_clr = 1'b0;
    chk("clr_unf", underflow, 0);
    chk("clr_ovf2", overflow, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h30 + i), 1);
      chk("wrap_count", count, 5);
    end
    for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 0);
    chk("wrap_full", full, 1);
    step(1, 8'h60, 1);
    chk("full_both_count", count, 7);
    chk("full_both_ovf", overflow, 1);
    while (mq.size() > 0) step(0, 8'h00, 1);
    chk("drained_empty", empty, 1);
    err_clr = 1'b1;
    step(0, 8'h00, 0);
    err_clr = 1'b0;
    step(1, 8'h77, 1);
    chk("empty_both_count", count, 1);
    chk("empty_both_unf", underflow, 1);
    chk("empty_both_valid", rd_valid, 0);
    step(0, 8'h00, 1);
    step(1, 8'h88, 0);
    step(1, 8'h99, 0);
    reset_n = 1'b0;
    step(0, 8'h00, 1);
    reset_n = 1'b1;
    chk("midrst_count", count, 0);
    chk("midrst_valid", rd_valid, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_unf", underflow, 0);
    step(0, 8'h00, 0);
    chk("exp_q_drained", exp_q.size(), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
